policy_request_arbiter: RTL and testbench

- Shares one n-set replacement-policy controller between two cache request ports, port 0 (instruction side) and port 1 (data side).
- Serializes the requests: hit updates become single-cycle hit pulses. A miss becomes a miss pulse, then a wait for the policy done, then a return of the victim block address to the requester.
- Round-robin arbitration with a per-miss timeout watchdog.
- Sits between the cache controllers and the policy controller. Operates at block-address granularity.

---
 rtl/policy_request_arbiter.sv | 126 ++++++++++++
 tb/tb_policy_request_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/policy_request_arbiter.sv
// Arbitrates two cache request ports onto one replacement-policy controller.
// Hits become one-cycle hit pulses; misses wait for done (or a watchdog).
module policy_request_arbiter #(
    parameter int unsigned CACHE_BLOCK_CAPACITY = 256,
    parameter int unsigned TIMEOUT_CYCLES       = 64,
    parameter int unsigned BW_TIMEOUT           = 8,
    localparam int unsigned BW_ADDR = $clog2(CACHE_BLOCK_CAPACITY)
) (
    input  logic               clock_i,
    input  logic               resetn_i,
    input  logic               req0_i,
    input  logic               req1_i,
    input  logic               miss0_i,
    input  logic               miss1_i,
    input  logic [BW_ADDR-1:0] addr0_i,
    input  logic [BW_ADDR-1:0] addr1_i,
    output logic               ack0_o,
    output logic               ack1_o,
    output logic [BW_ADDR-1:0] victim_o,
    output logic               err_o,
    output logic               pol_hit_o,
    output logic               pol_miss_o,
    output logic [BW_ADDR-1:0] pol_addr_o,
    input  logic               pol_done_i,
    input  logic [BW_ADDR-1:0] pol_addr_i
);

    typedef enum logic [2:0] {
        IDLE,
        HIT,
        MISS_ISSUE,
        MISS_WAIT,
        RESP
    } state_t;

    localparam logic [BW_TIMEOUT:0] TO_LIM = (BW_TIMEOUT+1)'(TIMEOUT_CYCLES);

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                miss_q, miss_d;
    logic                rr_q, rr_d;
    logic [BW_ADDR-1:0]  addr_q, addr_d;
    logic [BW_TIMEOUT-1:0] cnt_q, cnt_d;
    logic [BW_TIMEOUT:0] cnt_inc;
    logic [BW_ADDR-1:0]  victim_d;
    logic                err_d;
    logic                ack_d;

    assign cnt_inc    = {1'b0, cnt_q} + 1'b1;
    assign pol_addr_o = addr_q;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        miss_d   = miss_q;
        rr_d     = rr_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        victim_d = victim_o;
        err_d    = err_o;
        unique case (state_q)
            IDLE: begin
                if (req0_i || req1_i) begin
                    if (req0_i && req1_i) grant_d = rr_q;
                    else                  grant_d = req1_i;
                    rr_d    = ~grant_d;
                    miss_d  = grant_d ? miss1_i : miss0_i;
                    addr_d  = grant_d ? addr1_i : addr0_i;
                    state_d = miss_d ? MISS_ISSUE : HIT;
                end
            end
            HIT: state_d = IDLE;
            MISS_ISSUE: begin
                cnt_d   = '0;
                state_d = MISS_WAIT;
            end
            MISS_WAIT: begin
                // done takes priority over a timeout landing in the same cycle
                if (pol_done_i) begin
                    victim_d = pol_addr_i;
                    state_d  = RESP;
                end else if (TIMEOUT_CYCLES != 0 && cnt_inc == TO_LIM) begin
                    victim_d = addr_q;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_inc[BW_TIMEOUT-1:0];
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ack_d = (state_d == HIT) || (state_d == RESP);
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q    <= IDLE;
            grant_q    <= 1'b0;
            miss_q     <= 1'b0;
            rr_q       <= 1'b0;
            addr_q     <= '0;
            cnt_q      <= '0;
            victim_o   <= '0;
            err_o      <= 1'b0;
            ack0_o     <= 1'b0;
            ack1_o     <= 1'b0;
            pol_hit_o  <= 1'b0;
            pol_miss_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            miss_q     <= miss_d;
            rr_q       <= rr_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            victim_o   <= victim_d;
            err_o      <= err_d;
            ack0_o     <= ack_d && !grant_d;
            ack1_o     <= ack_d && grant_d;
            pol_hit_o  <= state_d == HIT;
            pol_miss_o <= state_d == MISS_ISSUE;
        end
    end

endmodule

// File: tb/tb_policy_request_arbiter.sv
// Bench for policy_request_arbiter: directed cases plus random single-port
// transactions against a transaction-level latency/victim model.
module tb_policy_request_arbiter;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       resetn_i;
  logic       req0_i, req1_i, miss0_i, miss1_i;
  logic [7:0] addr0_i, addr1_i;
  logic       ack0_o, ack1_o;
  logic [7:0] victim_o;
  logic       err_o, pol_hit_o, pol_miss_o;
  logic [7:0] pol_addr_o;
  logic       pol_done_i;
  logic [7:0] pol_addr_i;

  int n_chk  = 0;
  int n_fail = 0;

  bit         rr_m;
  bit         err_m;
  logic [7:0] victim_m;
  logic [7:0] paddr_m;

  policy_request_arbiter #(
    .CACHE_BLOCK_CAPACITY(256),
    .TIMEOUT_CYCLES(T),
    .BW_TIMEOUT(3)
  ) dut (
    .clock_i(clk),
    .resetn_i(resetn_i),
    .req0_i(req0_i),
    .req1_i(req1_i),
    .miss0_i(miss0_i),
    .miss1_i(miss1_i),
    .addr0_i(addr0_i),
    .addr1_i(addr1_i),
    .ack0_o(ack0_o),
    .ack1_o(ack1_o),
    .victim_o(victim_o),
    .err_o(err_o),
    .pol_hit_o(pol_hit_o),
    .pol_miss_o(pol_miss_o),
    .pol_addr_o(pol_addr_o),
    .pol_done_i(pol_done_i),
    .pol_addr_i(pol_addr_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_ack0", ack0_o, 8'(1'b0));
    chk("rst_ack1", ack1_o, 8'(1'b0));
    chk("rst_hit", pol_hit_o, 8'(1'b0));
    chk("rst_miss", pol_miss_o, 8'(1'b0));
    chk("rst_err", err_o, 8'(1'b0));
    chk("rst_victim", victim_o, 8'h00);
    chk("rst_paddr", pol_addr_o, 8'h00);
  endtask

  task automatic run_txn(input bit p, input bit m, input logic [7:0] a,
                         input int d, input bit stale,
                         input logic [7:0] pv);
    int ack_cyc;
    bit to;
    if (p) begin req1_i = 1'b1; miss1_i = m; addr1_i = a; end
    else   begin req0_i = 1'b1; miss0_i = m; addr0_i = a; end
    pol_addr_i = pv;
    pol_done_i = 1'b0;
    to = m && (d >= T);
    if (!m)      ack_cyc = 0;
    else if (to) ack_cyc = T + 1;
    else         ack_cyc = 2 + d;
    for (int c = 0; c <= ack_cyc + 1; c++) begin
      @(posedge clk);
      #1;
      pol_done_i = m && ((stale && c == 0) || (!to && c == 1 + d));
      if (c == ack_cyc) begin
        if (p) req1_i = 1'b0;
        else   req0_i = 1'b0;
        if (m) victim_m = to ? a : pv;
        if (to) err_m = 1'b1;
      end
      paddr_m = a;
      chk("ack0", ack0_o, 8'((c == ack_cyc) && !p));
      chk("ack1", ack1_o, 8'((c == ack_cyc) && p));
      chk("pol_hit", pol_hit_o, 8'(!m && (c == 0)));
      chk("pol_miss", pol_miss_o, 8'(m && (c == 0)));
      chk("pol_addr", pol_addr_o, paddr_m);
      chk("err", err_o, 8'(err_m));
      chk("victim", victim_o, victim_m);
    end
    pol_done_i = 1'b0;
    rr_m = ~p;
  endtask

  task automatic pair_hits(input int n, input logic [7:0] a0,
                           input logic [7:0] a1);
    bit w;
    bit g;
    w = rr_m;
    req0_i = 1'b1; miss0_i = 1'b0; addr0_i = a0;
    req1_i = 1'b1; miss1_i = 1'b0; addr1_i = a1;
    for (int c = 0; c < 2 * n; c++) begin
      @(posedge clk);
      #1;
      g = w ^ bit'((c / 2) % 2);
      if (c == 2 * n - 1) begin req0_i = 1'b0; req1_i = 1'b0; end
      chk("pair_ack0", ack0_o, 8'((c % 2 == 0) && !g));
      chk("pair_ack1", ack1_o, 8'((c % 2 == 0) && g));
      chk("pair_hit", pol_hit_o, 8'(c % 2 == 0));
      if (c % 2 == 0) begin
        paddr_m = g ? a1 : a0;
        chk("pair_addr", pol_addr_o, paddr_m);
      end
    end
    rr_m = ~(w ^ bit'((n - 1) % 2));
  endtask

  initial begin
    resetn_i = 1'b0;
    req0_i = 1'b0; req1_i = 1'b0; miss0_i = 1'b0; miss1_i = 1'b0;
    addr0_i = '0; addr1_i = '0;
    pol_done_i = 1'b0; pol_addr_i = '0;
    rr_m = 1'b0; err_m = 1'b0; victim_m = '0; paddr_m = '0;
    #2;
    check_reset_values();
    #20;
    resetn_i = 1'b1;
    @(posedge clk);
    #1;

    pair_hits(4, 8'h11, 8'h22);
    run_txn(1'b0, 1'b0, 8'h2A, 0, 1'b0, 8'h00);
    run_txn(1'b1, 1'b1, 8'h13, 2, 1'b0, 8'h93);
    run_txn(1'b0, 1'b1, 8'h40, 0, 1'b0, 8'hC1);
    run_txn(1'b1, 1'b1, 8'h55, 3, 1'b1, 8'h66);
    run_txn(1'b0, 1'b1, 8'h5A, T - 1, 1'b0, 8'hA5);
    run_txn(1'b1, 1'b1, 8'h07, 99, 1'b0, 8'hEE);
    chk("to_err", err_o, 8'(1'b1));
    chk("to_victim", victim_o, 8'h07);
    run_txn(1'b0, 1'b0, 8'h33, 0, 1'b0, 8'h00);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        pair_hits(int'($urandom_range(1, 3)), 8'($urandom),
                  8'($urandom));
      end else begin
        bit p, m, st;
        int d;
        p  = 1'($urandom_range(0, 1));
        m  = 1'($urandom_range(0, 1));
        d  = int'($urandom_range(0, T + 2));
        st = ($urandom_range(0, 3) == 0) && (d >= 1);
        run_txn(p, m, 8'($urandom), d, st, 8'($urandom));
      end
    end

    req1_i = 1'b1; miss1_i = 1'b1; addr1_i = 8'h77;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk("mr_miss", pol_miss_o, 8'(c == 0));
      chk("mr_ack1", ack1_o, 8'(1'b0));
    end
    #2;
    resetn_i = 1'b0;
    #1;
    check_reset_values();
    req1_i = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_noack0", ack0_o, 8'(1'b0));
    chk("mr_noack1", ack1_o, 8'(1'b0));
    #2;
    resetn_i = 1'b1;
    rr_m = 1'b0; err_m = 1'b0; victim_m = '0;
    @(posedge clk);
    #1;
    run_txn(1'b1, 1'b0, 8'h3C, 0, 1'b0, 8'h00);
    run_txn(1'b0, 1'b1, 8'h81, 1, 1'b0, 8'h18);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
